// File: rtl/instr_enc_pkg.sv
// Shared opcode constants, format classification and request layout for instr_encoder.
package instr_enc_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R, FMT_BAD} fmt_e;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } req_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: f = FMT_I;
      OP_STORE:                 f = FMT_S;
      OP_BRANCH:                f = FMT_B;
      OP_AUIPC, OP_LUI:         f = FMT_U;
      OP_JAL:                   f = FMT_J;
      OP_REG:                   f = FMT_R;
      default:                  f = FMT_BAD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/instr_encoder_imm_pack.sv
// Combinational field packer: request fields -> RV32I instruction word and range error.
// Range checking is built only when IMM_RANGE_CHECK_EN is defined.
module imm_pack
  import instr_enc_pkg::*;
(
  input  req_t        req,
  output logic [31:0] instr,
  output logic        err
);

  fmt_e fmt;
  assign fmt = fmt_of(req.opcode);

  always_comb begin
    instr = NOP_INSTR;
    case (fmt)
      FMT_I: instr = {req.imm[11:0], req.rs1, req.funct3, req.rd, req.opcode};
      FMT_S: instr = {req.imm[11:5], req.rs2, req.rs1, req.funct3, req.imm[4:0], req.opcode};
      FMT_B: instr = {req.imm[12], req.imm[10:5], req.rs2, req.rs1, req.funct3,
                      req.imm[4:1], req.imm[11], req.opcode};
      FMT_U: instr = {req.imm[31:12], req.rd, req.opcode};
      FMT_J: instr = {req.imm[20], req.imm[10:1], req.imm[11], req.imm[19:12], req.rd, req.opcode};
      FMT_R: instr = {req.funct7, req.rs2, req.rs1, req.funct3, req.rd, req.opcode};
      default: instr = NOP_INSTR;
    endcase
  end

`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits when every bit above the encodable field equals its sign bit.
  logic uni_is, uni_b, uni_j;
  assign uni_is = (&req.imm[31:11]) | ~(|req.imm[31:11]);
  assign uni_b  = (&req.imm[31:12]) | ~(|req.imm[31:12]);
  assign uni_j  = (&req.imm[31:20]) | ~(|req.imm[31:20]);

  always_comb begin
    err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: err = ~uni_is;
      FMT_B:        err = ~uni_b | req.imm[0];
      FMT_J:        err = ~uni_j | req.imm[0];
      FMT_U:        err = |req.imm[11:0];
      FMT_R:        err = 1'b0;
      default:      err = 1'b1;
    endcase
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: rtl/instr_encoder.sv
// Two-stage valid/ready RV32I instruction encoder with flush and output handshake counter.
// Optional immediate range checking via IMM_RANGE_CHECK_EN (see imm_pack).
module instr_encoder
  import instr_enc_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [6:0]       in_opcode,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [2:0]       in_funct3,
  input  logic [6:0]       in_funct7,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] out_count
);

  logic             rdy_q;
  logic             s1_valid, s2_valid;
  req_t             in_req, s1_req;
  logic [31:0]      s2_instr, enc_instr;
  logic             s2_err, enc_err;
  logic [CNT_W-1:0] count_q;
  logic             adv1, adv2, in_fire, out_fire;

  assign in_req = '{opcode: in_opcode, rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                    funct3: in_funct3, funct7: in_funct7, imm: in_imm};

  assign adv2     = ~s2_valid | out_ready;
  assign adv1     = ~s1_valid | adv2;
  // rdy_q keeps in_ready low until the first edge after reset release.
  assign in_ready = adv1 & ~flush & rdy_q;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = s2_valid & out_ready;

  imm_pack u_pack (
    .req   (s1_req),
    .instr (enc_instr),
    .err   (enc_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_q    <= 1'b0;
      s1_valid <= 1'b0;
      s1_req   <= '0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
      end else begin
        if (adv2) begin
          s2_valid <= s1_valid;
          if (s1_valid) begin
            s2_instr <= enc_instr;
            s2_err   <= enc_err;
          end
        end
        if (adv1) s1_valid <= in_fire;
        if (in_fire) s1_req <= in_req;
      end
    end
  end

  // Handshakes completing in a flush cycle still count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        count_q <= '0;
    else if (out_fire) count_q <= count_q + CNT_W'(1);
  end

  assign out_valid = s2_valid;
  assign out_instr = s2_instr;
  assign out_err   = s2_err;
  assign out_count = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder with a queue-based reference model.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [6:0]  in_opcode = '0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]  in_funct3 = '0;
  logic [6:0]  in_funct7 = '0;
  logic [31:0] in_imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic        out_err;
  logic [15:0] out_count;

  instr_encoder #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_err(out_err), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Format codes: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R, 6 unknown
  function automatic int fmt(input logic [6:0] op);
    case (op)
      7'h03, 7'h13, 7'h67: return 0;
      7'h23:               return 1;
      7'h63:               return 2;
      7'h17, 7'h37:        return 3;
      7'h6f:               return 4;
      7'h33:               return 5;
      default:             return 6;
    endcase
  endfunction

  function automatic logic in_range(input int f, input logic [31:0] imm);
    int s;
    s = int'(imm);
    case (f)
      0, 1:    return (s >= -2048) && (s <= 2047);
      2:       return (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
      3:       return imm[11:0] == 12'h000;
      4:       return (s >= -(1 << 20)) && (s <= (1 << 20) - 2) && (imm[0] == 1'b0);
      5:       return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_err(input logic [6:0] op, input logic [31:0] imm);
`ifdef IMM_RANGE_CHECK_EN
    return !in_range(fmt(op), imm);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] model_enc(input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [6:0] f7, input logic [31:0] imm);
    logic [31:0] base;
    base = (32'(f3) << 12) | 32'(op);
    case (fmt(op))
      0: return ((imm & 32'hfff) << 20) | (32'(rs1) << 15) | base | (32'(rd) << 7);
      1: return (((imm >> 5) & 32'h7f) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | base
                | ((imm & 32'h1f) << 7);
      2: return (((imm >> 12) & 1) << 31) | (((imm >> 5) & 32'h3f) << 25) | (32'(rs2) << 20)
                | (32'(rs1) << 15) | base | (((imm >> 1) & 32'hf) << 8) | (((imm >> 11) & 1) << 7);
      3: return (imm & 32'hfffff000) | (32'(rd) << 7) | 32'(op);
      4: return (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3ff) << 21)
                | (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hff) << 12) | (32'(rd) << 7) | 32'(op);
      5: return (32'(f7) << 25) | (32'(rs2) << 20) | (32'(rs1) << 15) | base | (32'(rd) << 7);
      default: return 32'h0000_0013;
    endcase
  endfunction

  function automatic logic [31:0] decode_imm(input int f, input logic [31:0] w);
    case (f)
      0:       return {{20{w[31]}}, w[31:20]};
      1:       return {{20{w[31]}}, w[31:25], w[11:7]};
      2:       return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3:       return {w[31:12], 12'h000};
      4:       return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      default: return 32'h0;
    endcase
  endfunction

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic [31:0] imm;
    int          f;
  } exp_t;

  exp_t        q[$];
  logic [15:0] cnt_m = '0;
  logic        rdy_m = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_instr = '0;
  logic        prev_err = 1'b0;

  // Reference model and compare process, sampled on the inactive clock edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      cnt_m = '0;
      rdy_m = 1'b0;
      prev_stall = 1'b0;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst out_count", 32'(out_count), 32'd0);
    end else begin
      check("in_ready", 32'(in_ready),
            32'(rdy_m && !flush && (q.size() < 2 || out_ready)));
      check("out_count", 32'(out_count), 32'(cnt_m));
      if (prev_stall) begin
        check("stall valid", 32'(out_valid), 32'd1);
        check("stall instr", out_instr, prev_instr);
        check("stall err", 32'(out_err), 32'(prev_err));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check("spurious word", 32'(q.size()), 32'd1);
        end else begin
          exp_t e;
          e = q.pop_front();
          check("word instr", out_instr, e.instr);
          check("word err", 32'(out_err), 32'(e.err));
          if (e.f <= 4 && in_range(e.f, e.imm))
            check("decode back", decode_imm(e.f, out_instr), e.imm);
        end
        cnt_m = cnt_m + 16'd1;
      end
      if (flush) q.delete();
      if (in_valid && in_ready) begin
        exp_t n;
        n.instr = model_enc(in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm);
        n.err   = model_err(in_opcode, in_imm);
        n.imm   = in_imm;
        n.f     = fmt(in_opcode);
        q.push_back(n);
      end
      prev_stall = out_valid && !out_ready && !flush;
      prev_instr = out_instr;
      prev_err   = out_err;
      rdy_m      = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
      input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] imm);
    in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
    in_funct3 = f3; in_funct7 = f7; in_imm = imm;
    in_valid  = 1'b1;
  endtask

  task automatic send_expect(input string name, input logic [6:0] op, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
      input logic [31:0] imm, input logic [31:0] exp_instr, input logic exp_err);
    bit ok;
    out_ready = 1'b1;
    drive(op, rd, rs1, rs2, f3, 7'h00, imm);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
      tick();
    end
    in_valid = 1'b0;
    check({name, " accept"}, 32'(ok), 32'd1);
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      ok = out_valid;
    end
    check({name, " arrive"}, 32'(ok), 32'd1);
    check({name, " instr"}, out_instr, exp_instr);
    check({name, " err"}, 32'(out_err), 32'(exp_err));
    tick();
  endtask

  logic [6:0] ops [9] = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h17, 7'h37, 7'h67, 7'h6f, 7'h33};
  logic [6:0] bad_ops [3] = '{7'h7f, 7'h0f, 7'h73};

  task automatic rand_req();
    int v;
    logic [6:0] op;
    if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 2)];
    else                           op = ops[$urandom_range(0, 8)];
    case (fmt(op))
      0, 1: v = int'($urandom_range(0, 4095)) - 2048;
      2:    v = (int'($urandom_range(0, 4095)) - 2048) * 2;
      3:    v = int'($urandom & 32'hfffff000);
      4:    v = (int'($urandom_range(0, 1048575)) - 524288) * 2;
      default: v = int'($urandom);
    endcase
    if ($urandom_range(0, 7) == 0) v = int'($urandom);
    in_opcode = op;
    in_rd     = 5'($urandom);
    in_rs1    = 5'($urandom);
    in_rs2    = 5'($urandom);
    in_funct3 = 3'($urandom);
    in_funct7 = 7'($urandom);
    in_imm    = v;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int acc, idx;
    logic [15:0] base;
    bit fire;

    // Pin the reference model with hand-computed words.
    check("model addi", model_enc(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5), 32'h0050_0093);
    check("model sw", model_enc(7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 7'd0, 32'hffff_fffc), 32'hfe21_ae23);
    check("model jal", model_enc(7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800), 32'h0010_00ef);
    check("model decode sw", decode_imm(1, 32'hfe21_ae23), 32'hffff_fffc);

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    tick();

    // ADDI latency: visible after the second edge following accept.
    out_ready = 1'b1;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
    @(negedge clk);
    check("addi in_ready", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("addi lat1 valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("addi lat2 valid", 32'(out_valid), 32'd1);
    check("addi instr", out_instr, 32'h0050_0093);
    check("addi err", 32'(out_err), 32'd0);
    @(negedge clk);
    check("addi count", 32'(out_count), 32'd1);
    tick();

    send_expect("sw", 7'h23, 5'd0, 5'd3, 5'd2, 3'b010, 32'hffff_fffc, 32'hfe21_ae23, 1'b0);
    send_expect("jal", 7'h6f, 5'd1, 5'd0, 5'd0, 3'd0, 32'h800, 32'h0010_00ef, 1'b0);
`ifdef IMM_RANGE_CHECK_EN
    send_expect("addi 2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b1);
    send_expect("bad op", 7'h7f, 5'd1, 5'd2, 5'd3, 3'd1, 32'd7, 32'h0000_0013, 1'b1);
`else
    send_expect("addi 2048", 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048, 32'h8000_0093, 1'b0);
    send_expect("bad op", 7'h7f, 5'd1, 5'd2, 5'd3, 3'd1, 32'd7, 32'h0000_0013, 1'b0);
`endif

    // Backpressure: three requests against four stalled cycles.
    base = cnt_m;
    out_ready = 1'b0;
    idx = 0;
    acc = 0;
    drive(7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd10);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        acc++;
        idx++;
        if (idx < 3) drive(7'h13, 5'(idx + 1), 5'd0, 5'd0, 3'd0, 7'd0, 32'(10 + idx));
        else in_valid = 1'b0;
      end
    end
    check("bp accepts", 32'(acc), 32'd2);
    check("bp in_ready low", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    for (int c = 0; c < 10 && idx < 3; c++) begin
      @(negedge clk);
      fire = in_valid && in_ready;
      tick();
      if (fire) begin
        idx++;
        in_valid = 1'b0;
      end
    end
    check("bp all accepted", 32'(idx), 32'd3);
    repeat (5) tick();
    check("bp count", 32'(out_count), 32'(base + 16'd3));

    // Flush with both stages full.
    out_ready = 1'b0;
    drive(7'h33, 5'd4, 5'd5, 5'd6, 3'd0, 7'h20, 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    base = cnt_m;
    @(negedge clk);
    check("pre-flush valid", 32'(out_valid), 32'd1);
    tick();
    flush = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    check("flush in_ready", 32'(in_ready), 32'd0);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post-flush valid", 32'(out_valid), 32'd0);
    check("post-flush count", 32'(out_count), 32'(base));
    tick();

    // Asynchronous reset mid-stream.
    drive(7'h37, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
    tick();
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst valid", 32'(out_valid), 32'd0);
    check("arst instr", out_instr, 32'd0);
    check("arst err", 32'(out_err), 32'd0);
    check("arst count", 32'(out_count), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release in_ready", 32'(in_ready), 32'd1);
    tick();

    // Randomized traffic with backpressure and occasional flush.
    for (int c = 0; c < 2500; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      rand_req();
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      tick();
    end
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    check("drain empty", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
